// File: rtl/mem_access.sv
// mem_access: memory-access stage between the execute ALU and writeback.
//
// The ALU result is either passed straight through (non-memory ops) or used
// as the effective address of a single data-bus request. Store data and byte
// strobes are lane-aligned to the 8-byte bus word; load data is shifted down,
// truncated to the access size and sign- or zero-extended. The stage holds
// off upstream (in_ready low) for the whole bus round-trip.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge;
// the consumer may change ready at any time. dreq_valid is held, with all
// request fields stable, until the cycle in which dresp_data_ok is seen.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     instruction handshake from execute
//   alu_result            effective address or non-memory result
//   store_data            rs2 value for stores
//   mem_op                0=none, 1=load, 2=store
//   msize, munsigned      access size (byte..double), zero-extend loads
//   rd                    destination register
//   dreq_*                data-bus request (valid/addr/size/strobe/data)
//   dresp_data_ok/data    bus completion and raw aligned read data
//   out_valid/out_ready   result handshake to writeback
//   out_data/out_rd       result value and destination register
//   out_misalign          misaligned-access exception flag
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// without issuing a bus request. Left undefined, out_misalign is always 0
// and misaligned accesses go to the bus with lanes that fall off the top of
// the 8-byte word dropped.

module mem_access #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [63:0]       store_data,
    input  logic [2:0]        mem_op,
    input  logic [1:0]        msize,
    input  logic              munsigned,
    input  logic [4:0]        rd,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [63:0]       dreq_data,
    input  logic              dresp_data_ok,
    input  logic [63:0]       dresp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic [4:0]        out_rd,
    output logic              out_misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q,        state_d;
    logic [ADDR_W-1:0] addr_q,         addr_d;
    logic [1:0]        size_q,         size_d;
    logic              unsigned_q,     unsigned_d;
    logic              is_store_q,     is_store_d;
    logic [4:0]        rd_q,           rd_d;
    logic [7:0]        strobe_q,       strobe_d;
    logic [63:0]       wdata_q,        wdata_d;
    logic              out_valid_q,    out_valid_d;
    logic [63:0]       out_data_q,     out_data_d;
    logic [4:0]        out_rd_q,       out_rd_d;
    logic              out_misalign_q, out_misalign_d;

    logic [2:0]  in_off;
    logic [7:0]  strobe_base;
    logic        trap;
    logic [63:0] load_raw;
    logic [63:0] load_ext;
    logic        accept;

    assign in_off = alu_result[2:0];
    assign accept = in_valid && in_ready;

    // Strobe pattern at lane 0; shifting an 8-bit value drops lanes that
    // would land past byte 7 on a misaligned access.
    always_comb begin
        strobe_base = 8'h00;
        case (msize)
            2'd0:    strobe_base = 8'h01;
            2'd1:    strobe_base = 8'h03;
            2'd2:    strobe_base = 8'h0F;
            default: strobe_base = 8'hFF;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        trap = 1'b0;
        case (msize)
            2'd0:    trap = 1'b0;
            2'd1:    trap = in_off[0];
            2'd2:    trap = (in_off[1:0] != 2'd0);
            default: trap = (in_off != 3'd0);
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    // Load path works on the latched address so the response may arrive in
    // any REQ cycle without the upstream inputs being held.
    assign load_raw = dresp_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = load_raw;
        case (size_q)
            2'd0: load_ext = unsigned_q ? {56'd0, load_raw[7:0]}
                                        : {{56{load_raw[7]}}, load_raw[7:0]};
            2'd1: load_ext = unsigned_q ? {48'd0, load_raw[15:0]}
                                        : {{48{load_raw[15]}}, load_raw[15:0]};
            2'd2: load_ext = unsigned_q ? {32'd0, load_raw[31:0]}
                                        : {{32{load_raw[31]}}, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        is_store_d     = is_store_q;
        rd_d           = rd_q;
        strobe_d       = strobe_q;
        wdata_d        = wdata_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_rd_d       = out_rd_q;
        out_misalign_d = out_misalign_q;

        // Result consumed; a new result below may immediately replace it.
        if (out_valid_q && out_ready) begin
            out_valid_d    = 1'b0;
            out_misalign_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (mem_op == 3'd0) begin
                        out_valid_d    = 1'b1;
                        out_data_d     = 64'(alu_result);
                        out_rd_d       = rd;
                        out_misalign_d = 1'b0;
                    end else if (trap) begin
                        out_valid_d    = 1'b1;
                        out_data_d     = 64'(alu_result);
                        out_rd_d       = 5'd0;
                        out_misalign_d = 1'b1;
                    end else begin
                        addr_d     = alu_result;
                        size_d     = msize;
                        unsigned_d = munsigned;
                        is_store_d = (mem_op == 3'd2);
                        rd_d       = rd;
                        strobe_d   = (mem_op == 3'd2) ? (strobe_base << in_off) : 8'h00;
                        wdata_d    = store_data << {in_off, 3'b000};
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dresp_data_ok) begin
                    out_valid_d    = 1'b1;
                    out_data_d     = is_store_q ? 64'd0 : load_ext;
                    out_rd_d       = is_store_q ? 5'd0 : rd_q;
                    out_misalign_d = 1'b0;
                    state_d        = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            size_q         <= 2'd0;
            unsigned_q     <= 1'b0;
            is_store_q     <= 1'b0;
            rd_q           <= 5'd0;
            strobe_q       <= 8'h00;
            wdata_q        <= 64'd0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 64'd0;
            out_rd_q       <= 5'd0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            is_store_q     <= is_store_d;
            rd_q           <= rd_d;
            strobe_q       <= strobe_d;
            wdata_q        <= wdata_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_rd_q       <= out_rd_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    assign dreq_valid   = (state_q == S_REQ);
    assign dreq_addr    = addr_q;
    assign dreq_size    = {1'b0, size_q};
    assign dreq_strobe  = strobe_q;
    assign dreq_data    = wdata_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_rd       = out_rd_q;
    assign out_misalign = out_misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads with sign/zero
// extension, lane-aligned stores, backpressure, async reset during a bus
// request and the misaligned-access behaviour of the selected build.

module tb_mem_access;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [2:0]  mem_op;
    logic [1:0]  msize;
    logic        munsigned;
    logic [4:0]  rd;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;

    int n_checks = 0;
    int n_errors = 0;

    mem_access #(.ADDR_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .mem_op        (mem_op),
        .msize         (msize),
        .munsigned     (munsigned),
        .rd            (rd),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_misalign  (out_misalign)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // driver tasks; all driving happens 1ns after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [1:0] sz, input logic uns,
                            input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] r);
        in_valid   = 1'b1;
        mem_op     = op;
        msize      = sz;
        munsigned  = uns;
        alu_result = addr;
        store_data = sd;
        rd         = r;
    endtask

    // Response in the first REQ cycle, then consume the result.
    task automatic finish_req(input logic [63:0] rdata);
        dresp_data    = rdata;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
    endtask

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; store_data = '0;
        mem_op = 3'd0; msize = 2'd0; munsigned = 1'b0; rd = 5'd0;
        dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_dreq_valid", dreq_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_rd", out_rd, 0);
        check_eq("rst_misalign", out_misalign, 0);
        check_eq("rst_strobe", dreq_strobe, 0);
        reset = 1'b0;
        step();

        // non-memory pass-through
        drive_op(3'd0, 2'd0, 1'b0, 64'h1234, 64'd0, 5'd5);
        check_eq("nm_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_eq("nm_out_valid", out_valid, 1);
        check_eq("nm_out_data", out_data, 64'h1234);
        check_eq("nm_out_rd", out_rd, 5);
        check_eq("nm_no_dreq", dreq_valid, 0);
        step();
        check_eq("nm_consumed", out_valid, 0);

        // back-to-back non-memory ops at one per cycle
        for (int i = 0; i < 3; i++) begin
            drive_op(3'd0, 2'd0, 1'b0, 64'h100 + 64'(i), 64'd0, 5'(10 + i));
            step();
            check_eq("b2b_out_valid", out_valid, 1);
            check_eq("b2b_out_data", out_data, 64'h100 + 64'(i));
            check_eq("b2b_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();

        // LB sign-extended, response 3 cycles after accept, then backpressure
        drive_op(3'd1, 2'd0, 1'b0, 64'h1003, 64'd0, 5'd7);
        step();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        dresp_data = 64'h00000000_80000000;
        check_eq("lb_dreq_valid", dreq_valid, 1);
        check_eq("lb_dreq_addr", dreq_addr, 64'h1003);
        check_eq("lb_dreq_size", dreq_size, 0);
        check_eq("lb_strobe", dreq_strobe, 0);
        check_eq("lb_in_ready_1", in_ready, 0);
        step();
        check_eq("lb_in_ready_2", in_ready, 0);
        check_eq("lb_dreq_held", dreq_valid, 1);
        step();
        check_eq("lb_in_ready_3", in_ready, 0);
        finish_req(64'h00000000_80000000);
        check_eq("lb_out_valid", out_valid, 1);
        check_eq("lb_out_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("lb_out_rd", out_rd, 7);
        check_eq("lb_dreq_drop", dreq_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_out_data", out_data, 64'hFFFF_FFFF_FFFF_FF80);
            check_eq("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_release_valid", out_valid, 0);
        check_eq("bp_release_ready", in_ready, 1);

        // LWU, response in the first REQ cycle
        drive_op(3'd1, 2'd2, 1'b1, 64'h1004, 64'd0, 5'd12);
        step();
        in_valid = 1'b0;
        check_eq("lwu_dreq_valid", dreq_valid, 1);
        finish_req(64'hDEADBEEF_00000000);
        check_eq("lwu_out_valid", out_valid, 1);
        check_eq("lwu_out_data", out_data, 64'h00000000_DEADBEEF);
        check_eq("lwu_out_rd", out_rd, 12);
        step();

        // SH with lane alignment, request held for two cycles
        drive_op(3'd2, 2'd1, 1'b0, 64'h2006, 64'hABCD, 5'd9);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_eq("sh_dreq_valid", dreq_valid, 1);
            check_eq("sh_strobe", dreq_strobe, 8'hC0);
            check_eq("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
            check_eq("sh_size", dreq_size, 1);
            step();
        end
        finish_req(64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("sh_out_valid", out_valid, 1);
        check_eq("sh_out_rd", out_rd, 0);
        check_eq("sh_out_data", out_data, 0);
        step();

        // LH sign-extended from bit 15
        drive_op(3'd1, 2'd1, 1'b0, 64'h3002, 64'd0, 5'd3);
        step();
        in_valid = 1'b0;
        finish_req(64'h0000_0000_8001_0000);
        check_eq("lh_out_data", out_data, 64'hFFFF_FFFF_FFFF_8001);
        check_eq("lh_out_rd", out_rd, 3);
        step();

        // LD unmodified
        drive_op(3'd1, 2'd3, 1'b0, 64'h3000, 64'd0, 5'd4);
        step();
        in_valid = 1'b0;
        check_eq("ld_dreq_size", dreq_size, 3);
        finish_req(64'h81234567_89ABCDEF);
        check_eq("ld_out_data", out_data, 64'h81234567_89ABCDEF);
        step();

        // stray response while idle is ignored
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        check_eq("stray_out_valid", out_valid, 0);
        check_eq("stray_dreq_valid", dreq_valid, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        // LW at 0x1002 traps without a bus request
        drive_op(3'd1, 2'd2, 1'b0, 64'h1002, 64'd0, 5'd8);
        step();
        in_valid = 1'b0;
        check_eq("trap_out_valid", out_valid, 1);
        check_eq("trap_misalign", out_misalign, 1);
        check_eq("trap_out_rd", out_rd, 0);
        check_eq("trap_out_data", out_data, 64'h1002);
        check_eq("trap_no_dreq", dreq_valid, 0);
        step();
        check_eq("trap_cleared", out_misalign, 0);
        check_eq("trap_still_no_dreq", dreq_valid, 0);
`else
        // misaligned LW issues normally
        drive_op(3'd1, 2'd2, 1'b0, 64'h1002, 64'd0, 5'd8);
        step();
        in_valid = 1'b0;
        check_eq("mis_lw_dreq_valid", dreq_valid, 1);
        check_eq("mis_lw_misalign", out_misalign, 0);
        finish_req(64'h0000_0000_5566_0000);
        check_eq("mis_lw_data", out_data, 64'h0000_0000_0000_5566);
        step();
        // misaligned SW: strobe and data lanes beyond byte 7 are dropped
        drive_op(3'd2, 2'd2, 1'b0, 64'h1006, 64'h11223344, 5'd8);
        step();
        in_valid = 1'b0;
        check_eq("mis_sw_strobe", dreq_strobe, 8'hC0);
        check_eq("mis_sw_data", dreq_data, 64'h3344_0000_0000_0000);
        finish_req(64'd0);
        check_eq("mis_sw_misalign", out_misalign, 0);
        step();
`endif

        // asynchronous reset during REQ
        drive_op(3'd1, 2'd0, 1'b0, 64'h4000, 64'd0, 5'd6);
        step();
        in_valid = 1'b0;
        check_eq("rreq_dreq_valid", dreq_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rreq_dreq_drop", dreq_valid, 0);
        check_eq("rreq_out_valid", out_valid, 0);
        step();
        reset = 1'b0;
        step();
        check_eq("rreq_idle_dreq", dreq_valid, 0);
        check_eq("rreq_idle_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute ALU. It takes the 64-bit ALU result as an effective address (or passes it through for non-memory ops) and drives the data bus with a held-valid request. It aligns store data and byte strobes, and extracts and sign- or zero-extends load data. A registered, handshaked result goes to writeback, and upstream stalls for the full bus round-trip.

## Interface
Parameters:
- `ADDR_W`, 64, address width taken from the ALU result.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute stage presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `alu_result`  in  64  effective address, or result for non-memory ops.
- `store_data`  in  64  rs2 value for stores.
- `mem_op`  in  3  0=none, 1=load, 2=store.
- `msize`  in  2  0=byte, 1=half, 2=word, 3=double.
- `munsigned`  in  1  zero-extend loads (LBU/LHU/LWU).
- `rd`  in  5  destination register, passed through.
- `dreq_valid`  out  1  bus request valid, held until `dresp_data_ok`.
- `dreq_addr`  out  64  request address.
- `dreq_size`  out  3  {0,msize}.
- `dreq_strobe`  out  8  byte-write mask; 0 for loads.
- `dreq_data`  out  64  lane-aligned store data.
- `dresp_data_ok`  in  1  bus completes the request this cycle.
- `dresp_data`  in  64  raw 8-byte-aligned read data.
- `out_valid`  out  1  result valid to writeback.
- `out_ready`  in  1  writeback consumes the result.
- `out_data`  out  64  load result or passed-through `alu_result`.
- `out_rd`  out  5  destination register.
- `out_misalign`  out  1  misaligned-access exception flag (see Configuration).

## Operation
- FSM states: IDLE, REQ, DONE. Reset puts the FSM in IDLE with all outputs 0.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- IDLE, accept with mem_op==0: next cycle `out_valid`=1, `out_data`=`alu_result`, `out_rd`=`rd`, and the FSM stays in IDLE.
- IDLE, accept with mem_op!=0: latch addr, size, data, and rd, then go to REQ.
- REQ: `dreq_valid`=1 with all request fields stable from latched values. On `dresp_data_ok`, latch the processed data and go to DONE. `addr_ok` is not used.
- DONE: `out_valid`=1. On `out_ready`, return to IDLE.
- Let `off` = addr[2:0]:
  - Strobe: byte 8'h01<<off, half 8'h03<<off, word 8'h0F<<off, double 8'hFF.
  - `dreq_data` = store_data << (8*off).
  - Load: raw = dresp_data >> (8*off). Truncate to size, then sign-extend bit 7/15/31, or zero-extend if `munsigned`. Doubles are unmodified.
- Stores complete with `out_rd` forced to 0 and `out_data`=0.
- `out_valid`/`out_data`/`out_rd` hold until `out_ready`.

## Timing
- Non-memory op latency: 1 cycle from accept to `out_valid`.
- Memory op:
  - Accept at cycle T.
  - `dreq_valid` from T+1.
  - `dresp_data_ok` at cycle N ≥ T+1 gives `out_valid` at N+1. `dreq_valid` drops at N+1.
- `dresp_data_ok` in the first REQ cycle is legal; minimum round-trip is 2 cycles accept-to-result.
- `out_valid` and `in_ready` both high in the same cycle with `out_ready`=1 gives back-to-back throughput of 1/cycle for non-memory ops.
- Asynchronous reset mid-REQ drops `dreq_valid` immediately and returns to IDLE. The bus is reset concurrently, so no stale response is expected.
- `dresp_data_ok` outside REQ is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - An access with addr not aligned to its size never enters REQ; no bus request is issued.
  - Next cycle the stage presents `out_valid`=1, `out_misalign`=1, `out_rd`=0, `out_data`=addr.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `out_misalign` is tied 0.
  - Misaligned accesses issue normally. `off` is used as-is and the strobe is truncated to 8 bits; the bytes that would shift out are dropped.

## Test plan
- Non-memory: accept `alu_result`=64'h1234, rd=5 → next cycle `out_valid`=1, `out_data`=64'h1234, `out_rd`=5, with no `dreq_valid`.
- LB sign: addr=0x1003, `dresp_data`=64'h00000000_80000000, data_ok 3 cycles later → `out_data`=64'hFFFF_FFFF_FFFF_FF80. `in_ready`=0 throughout.
- LWU: addr=0x1004, `dresp_data`=64'hDEADBEEF_00000000 → `out_data`=64'h00000000_DEADBEEF.
- SH: addr=0x2006, `store_data`=64'hABCD → `dreq_strobe`=8'hC0, `dreq_data`=64'hABCD_0000_0000_0000, `dreq_size`=3'd1, held until data_ok.
- Backpressure: `out_ready`=0 for 4 cycles after a load → `out_data` stable and `in_ready`=0. Release → IDLE, then the next instruction is accepted.
- Reset asserted during REQ → `dreq_valid`=0 and `out_valid`=0 immediately. With `MEM_MISALIGN_TRAP_EN`: LW at 0x1002 → `out_misalign`=1 and no bus request.
